intpol2_iq_fifo: RTL

INTPOL2_IQ_FIFO -- requirements
Module: intpol2_iq_fifo

---
 rtl/intpol2_pkg.sv | 20 ++
 rtl/intpol2_iq_fifo_mem.sv | 45 ++++
 rtl/intpol2_iq_fifo.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/intpol2_pkg.sv
// -----------------------------------------------------------------------------
// intpol2_pkg
// Shared constants for the interpolator IQ FIFO slice: default sample width,
// default address width / depth, default almost-full margin and the width of
// one paired I/Q storage entry.
// -----------------------------------------------------------------------------
package intpol2_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_AFULL_MARGIN = 2;

    // One storage entry carries I in the upper half and Q in the lower half.
    function automatic int iq_width(input int data_width);
        return 2 * data_width;
    endfunction

    localparam int IQ_WIDTH = iq_width(DEF_DATA_WIDTH);

endpackage : intpol2_pkg

// File: rtl/intpol2_iq_fifo_mem.sv
// -----------------------------------------------------------------------------
// intpol2_iq_fifo_mem
// Simple dual-port storage array for the IQ FIFO: synchronous write,
// asynchronous (combinational) read so the FIFO can present its head entry
// with zero latency.
//
// Ports:
//   clk      in   clock, write on posedge
//   wr_en    in   write strobe
//   wr_addr  in   [ADDR_WIDTH-1:0] write address
//   wr_data  in   [WIDTH-1:0] write data
//   rd_addr  in   [ADDR_WIDTH-1:0] read address
//   rd_data  out  [WIDTH-1:0] read data (combinational)
// -----------------------------------------------------------------------------
module intpol2_iq_fifo_mem
    import intpol2_pkg::*;
#(
    parameter int WIDTH      = IQ_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset on purpose; contents are only meaningful
    // behind the pointers, and a reset would prevent mapping onto RAM cells.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : intpol2_iq_fifo_mem

// File: rtl/intpol2_iq_fifo.sv
// -----------------------------------------------------------------------------
// intpol2_iq_fifo
// Show-ahead synchronous FIFO storing paired I/Q samples. Pointers are
// ADDR_WIDTH+1 bits; occupancy and status flags are registered and move in
// the same cycle as the pointers. A push while full is accepted only when a
// pop happens in the same cycle.
//
// Optional feature: define INTPOL2_FIFO_ERR_EN to add the sticky overflow /
// underflow ports. Without it, dropped writes and ignored reads are silent.
//
// Ports:
//   clk          in   clock
//   rstn         in   synchronous active-low reset
//   clear        in   synchronous flush (beats wr_en / rd_en)
//   wr_en        in   push request
//   data_in_I    in   [DATA_WIDTH-1:0] I sample to push
//   data_in_Q    in   [DATA_WIDTH-1:0] Q sample to push
//   rd_en        in   pop request
//   data_out_I   out  [DATA_WIDTH-1:0] head I sample
//   data_out_Q   out  [DATA_WIDTH-1:0] head Q sample
//   empty        out  no entries
//   full         out  DEPTH entries
//   almost_full  out  count >= DEPTH - AFULL_MARGIN
//   count        out  [ADDR_WIDTH:0] occupancy
//   overflow     out  sticky dropped-write flag (INTPOL2_FIFO_ERR_EN only)
//   underflow    out  sticky ignored-read flag  (INTPOL2_FIFO_ERR_EN only)
// -----------------------------------------------------------------------------
module intpol2_iq_fifo
    import intpol2_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in_I,
    input  logic [DATA_WIDTH-1:0] data_in_Q,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out_I,
    output logic [DATA_WIDTH-1:0] data_out_Q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
`ifdef INTPOL2_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH + 1)'(DEPTH - AFULL_MARGIN);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q,  count_d;
    logic                empty_q,  empty_d;
    logic                full_q,   full_d;
    logic                afull_q,  afull_d;
    logic                wr_fire,  rd_fire;
    logic                mem_we;
    logic [2*DATA_WIDTH-1:0] rd_data;

    // When full, a push is only accepted alongside a pop: the slot being
    // written is the head slot that the pop releases on the same edge.
    assign wr_fire = wr_en && (!full_q || rd_en);
    assign rd_fire = rd_en && !empty_q;
    assign mem_we  = wr_fire && !clear && rstn;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_fire) wr_ptr_d = wr_ptr_q + ONE;
        if (rd_fire) rd_ptr_d = rd_ptr_q + ONE;

        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // Flags come from the next count so they line up with the pointers.
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        afull_d = (count_d >= AFULL_C);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

`ifdef INTPOL2_FIFO_ERR_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wr_en && full_q && !rd_en);
        underflow_d = underflow_q || (rd_en && empty_q);
        if (clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    intpol2_iq_fifo_mem #(
        .WIDTH      (2 * DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data ({data_in_I, data_in_Q}),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    assign data_out_I  = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign data_out_Q  = rd_data[DATA_WIDTH-1:0];
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign count       = count_q;

endmodule : intpol2_iq_fifo
